mix_columns_seq: RTL and testbench

Iterative AES MixColumns stage that sits directly downstream of shift_rows in the round datapath. It accepts a 128-bit state on a valid/ready handshake and applies the MixColumns matrix to COLS_PER_CYCLE 32-bit columns per clock. It presents the mixed state to add_round_key on a second valid/ready handshake. A per-block bypass passes the final round through unmixed.

---
 rtl/mix_columns_seq.sv | 195 +++++++++++++++++++
 tb/tb_mix_columns_seq.sv | 264 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/mix_columns_seq.sv
// mix_columns_seq: iterative AES MixColumns stage.
// Accepts a 128-bit state on a valid/ready handshake and mixes
// COLS_PER_CYCLE 32-bit columns per clock. It returns the mixed state on a
// second valid/ready handshake. A per-block bypass skips the mixing for the
// final round.
// Optional build macro INV_MIX_EN adds an 'inverse' input that selects
// InvMixColumns for the block being accepted.
module mix_columns_seq #(
  parameter int COLS_PER_CYCLE = 1
) (
  input  logic         clk,
  input  logic         n_rst,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [127:0] data_in,
  input  logic         bypass,
`ifdef INV_MIX_EN
  input  logic         inverse,
`endif
  output logic         out_valid,
  input  logic         out_ready,
  output logic [127:0] data_out,
  output logic         busy
);

  // Only 1, 2 or 4 columns per cycle divide the four-column state evenly.
  if (!(COLS_PER_CYCLE == 1 || COLS_PER_CYCLE == 2 || COLS_PER_CYCLE == 4)) begin : g_bad_cols
    $error("mix_columns_seq: COLS_PER_CYCLE must be 1, 2 or 4");
  end

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_PROC = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Counter step and the counter value of the last PROC cycle.
  // For 4 columns per cycle the step wraps to 0 and the first cycle is the last.
  localparam logic [1:0] CNT_STEP = 2'(COLS_PER_CYCLE);
  localparam logic [1:0] CNT_LAST = 2'(4 - COLS_PER_CYCLE);

  // GF(2^8) multiply by 2, reducing by the AES polynomial.
  function automatic logic [7:0] xtime(input logic [7:0] a);
    return {a[6:0], 1'b0} ^ (a[7] ? 8'h1B : 8'h00);
  endfunction

  // Forward MixColumns on one column (row 0 in the top byte).
  function automatic logic [31:0] mix_fwd(input logic [31:0] col);
    logic [7:0] a0, a1, a2, a3;
    logic [7:0] b0, b1, b2, b3;
    a0 = col[31:24];
    a1 = col[23:16];
    a2 = col[15:8];
    a3 = col[7:0];
    b0 = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
    b1 = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
    b2 = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
    b3 = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
    return {b0, b1, b2, b3};
  endfunction

  // InvMixColumns on one column: coefficients 0E,0B,0D,09 rotated per row.
  function automatic logic [31:0] mix_inv(input logic [31:0] col);
    logic [7:0] a  [4];
    logic [7:0] m9 [4];
    logic [7:0] mb [4];
    logic [7:0] md [4];
    logic [7:0] me [4];
    logic [7:0] m2, m4, m8;
    for (int k = 0; k < 4; k++) begin
      a[k]  = col[31-8*k -: 8];
      m2    = xtime(a[k]);
      m4    = xtime(m2);
      m8    = xtime(m4);
      m9[k] = m8 ^ a[k];
      mb[k] = m8 ^ m2 ^ a[k];
      md[k] = m8 ^ m4 ^ a[k];
      me[k] = m8 ^ m4 ^ m2;
    end
    return {me[0] ^ mb[1] ^ md[2] ^ m9[3],
            m9[0] ^ me[1] ^ mb[2] ^ md[3],
            md[0] ^ m9[1] ^ me[2] ^ mb[3],
            mb[0] ^ md[1] ^ m9[2] ^ me[3]};
  endfunction

  state_t         state_q, state_d;
  logic [1:0]     cnt_q, cnt_d;
  logic [127:0]   work_q, work_d;
  logic           in_ready_q, out_valid_q, busy_q;
  logic           inv_mode_s;
  logic           accept_s;

`ifdef INV_MIX_EN
  logic inv_q, inv_d;

  // Direction of the block in flight, captured on the accept edge.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      inv_q <= 1'b0;
    end else begin
      inv_q <= inv_d;
    end
  end

  // Hold the direction except on the accept edge.
  always_comb begin
    inv_d = inv_q;
    if (accept_s) begin
      inv_d = inverse;
    end else begin
      inv_d = inv_q;
    end
  end

  assign inv_mode_s = inv_q;
`else
  assign inv_mode_s = 1'b0;
`endif

  assign accept_s = (state_q == ST_IDLE) && in_valid && in_ready_q;

  // Next-state logic: load on accept, mix a window of columns in PROC, hand off in DONE.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    work_d  = work_q;
    case (state_q)
      ST_IDLE: begin
        if (accept_s) begin
          work_d  = data_in;
          cnt_d   = 2'd0;
          state_d = bypass ? ST_DONE : ST_PROC;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_PROC: begin
        // Columns cnt_q .. cnt_q+COLS_PER_CYCLE-1, lowest word first.
        for (int j = 0; j < COLS_PER_CYCLE; j++) begin
          logic [1:0]  idx;
          logic [31:0] col;
          idx = cnt_q + 2'(j);
          col = work_q[{idx, 5'd0} +: 32];
          if (inv_mode_s) begin
            work_d[{idx, 5'd0} +: 32] = mix_inv(col);
          end else begin
            work_d[{idx, 5'd0} +: 32] = mix_fwd(col);
          end
        end
        cnt_d = cnt_q + CNT_STEP;
        if (cnt_q == CNT_LAST) begin
          state_d = ST_DONE;
        end else begin
          state_d = ST_PROC;
        end
      end
      ST_DONE: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        state_d = ST_IDLE;
        cnt_d   = 2'd0;
      end
    endcase
  end

  // State, counter, working register and registered handshake outputs.
  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state_q     <= ST_IDLE;
      cnt_q       <= 2'd0;
      work_q      <= 128'h0;
      in_ready_q  <= 1'b1;
      out_valid_q <= 1'b0;
      busy_q      <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      work_q      <= work_d;
      in_ready_q  <= (state_d == ST_IDLE);
      out_valid_q <= (state_d == ST_DONE);
      busy_q      <= (state_d != ST_IDLE);
    end
  end

  assign in_ready  = in_ready_q;
  assign out_valid = out_valid_q;
  assign busy      = busy_q;
  assign data_out  = work_q;

endmodule

// File: tb/tb_mix_columns_seq.sv
// Self-checking bench for mix_columns_seq. Three instances (1, 2 and 4
// columns per cycle) share one stimulus stream. Results come from a
// matrix-times-vector GF(2^8) model kept in this file.
module tb_mix_columns_seq;

`ifdef INV_MIX_EN
  localparam int INV_ON = 1;
`else
  localparam int INV_ON = 0;
`endif

  logic         clk;
  logic         n_rst;
  logic         in_valid;
  logic [127:0] data_in;
  logic         bypass;
  logic         inverse_s;
  logic         out_ready;
  logic [2:0]   in_ready_s;
  logic [2:0]   out_valid_s;
  logic [2:0]   busy_s;
  logic [127:0] data_out_s [3];

  int n_cmp;
  int n_bad;

  mix_columns_seq #(.COLS_PER_CYCLE(1)) u_c1 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_s[0]),
    .data_in(data_in), .bypass(bypass),
`ifdef INV_MIX_EN
    .inverse(inverse_s),
`endif
    .out_valid(out_valid_s[0]), .out_ready(out_ready), .data_out(data_out_s[0]), .busy(busy_s[0]));

  mix_columns_seq #(.COLS_PER_CYCLE(2)) u_c2 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_s[1]),
    .data_in(data_in), .bypass(bypass),
`ifdef INV_MIX_EN
    .inverse(inverse_s),
`endif
    .out_valid(out_valid_s[1]), .out_ready(out_ready), .data_out(data_out_s[1]), .busy(busy_s[1]));

  mix_columns_seq #(.COLS_PER_CYCLE(4)) u_c4 (
    .clk(clk), .n_rst(n_rst), .in_valid(in_valid), .in_ready(in_ready_s[2]),
    .data_in(data_in), .bypass(bypass),
`ifdef INV_MIX_EN
    .inverse(inverse_s),
`endif
    .out_valid(out_valid_s[2]), .out_ready(out_ready), .data_out(data_out_s[2]), .busy(busy_s[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Generic GF(2^8) product by shift-and-add.
  function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
    logic [7:0] p = 8'h00;
    logic [7:0] x = a;
    for (int i = 0; i < 8; i++) begin
      if (b[i]) p = p ^ x;
      x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1B : 8'h00);
    end
    return p;
  endfunction

  // Whole-state reference: circulant matrix times each column, or pass-through.
  function automatic logic [127:0] ref_state(input logic [127:0] d, input logic byp, input logic inv);
    logic [7:0]   coef [4];
    logic [127:0] r;
    logic [7:0]   acc;
    if (byp) return d;
    if (inv) coef = '{8'h0E, 8'h0B, 8'h0D, 8'h09};
    else     coef = '{8'h02, 8'h03, 8'h01, 8'h01};
    r = 128'h0;
    for (int c = 0; c < 4; c++) begin
      for (int row = 0; row < 4; row++) begin
        acc = 8'h00;
        for (int k = 0; k < 4; k++)
          acc = acc ^ gmul(d[32*c + 31 - 8*k -: 8], coef[(k - row + 4) % 4]);
        r[32*c + 31 - 8*row -: 8] = acc;
      end
    end
    return r;
  endfunction

  function automatic logic [127:0] rand128();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  task automatic test_reset();
    n_rst = 1'b0; in_valid = 1'b0; data_in = 128'h0; bypass = 1'b0;
    inverse_s = 1'b0; out_ready = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (in_ready_s[i] !== 1'b1 || out_valid_s[i] !== 1'b0 || busy_s[i] !== 1'b0 ||
          data_out_s[i] !== 128'h0) begin
        n_bad++;
        $display("FAIL reset inst%0d: rdy=%b vld=%b busy=%b dout=%h, required 1 0 0 0",
                 i, in_ready_s[i], out_valid_s[i], busy_s[i], data_out_s[i]);
      end
    end
    n_rst = 1'b1;
    @(negedge clk);
  endtask

  // Known vectors, bypass, inverse and random blocks with exact latency tracking.
  task automatic test_blocks();
    logic [127:0] kd [4];
    logic [127:0] ke [4];
    logic         kb [4];
    logic         ki [4];
    logic [127:0] d, e;
    logic         b, inv;
    int           lat;
    int           nknown;
    kd[0] = 128'hdb135345_f20a225c_01010101_c6c6c6c6; ke[0] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6; kb[0] = 1'b0; ki[0] = 1'b0;
    kd[1] = 128'hd4d4d4d5_2d26314c_00000000_ffffffff; ke[1] = 128'hd5d5d7d6_4d7ebdf8_00000000_ffffffff; kb[1] = 1'b0; ki[1] = 1'b0;
    kd[2] = 128'h01234567_89abcdef_fedcba98_76543210; ke[2] = 128'h01234567_89abcdef_fedcba98_76543210; kb[2] = 1'b1; ki[2] = 1'b0;
    kd[3] = 128'h8e4da1bc_9fdc589d_01010101_c6c6c6c6; ke[3] = 128'hdb135345_f20a225c_01010101_c6c6c6c6; kb[3] = 1'b0; ki[3] = 1'b1;
    nknown = 3 + INV_ON;
    out_ready = 1'b1;
    for (int v = 0; v < nknown + 14; v++) begin
      if (v < nknown) begin
        d = kd[v]; e = ke[v]; b = kb[v]; inv = ki[v];
      end else begin
        d   = rand128();
        b   = ($urandom_range(0, 3) == 0);
        inv = (INV_ON != 0) ? 1'($urandom_range(0, 1)) : 1'b0;
        e   = ref_state(d, b, inv);
      end
      @(negedge clk);
      in_valid = 1'b1; data_in = d; bypass = b; inverse_s = inv;
      @(posedge clk);
      #1;
      // Later input changes must not affect the block in flight.
      in_valid = 1'b0; data_in = rand128(); bypass = ~b; inverse_s = (INV_ON != 0) ? ~inv : 1'b0;
      for (int k = 0; k < 6; k++) begin
        if (k > 0) @(negedge clk);
        else       @(negedge clk);
        for (int i = 0; i < 3; i++) begin
          lat = b ? 0 : (4 >> i);
          n_cmp++;
          if (out_valid_s[i] !== (k == lat) || in_ready_s[i] !== (k > lat) || busy_s[i] !== (k <= lat)) begin
            n_bad++;
            $display("FAIL hs blk%0d inst%0d k=%0d: vld=%b rdy=%b busy=%b, required %b %b %b",
                     v, i, k, out_valid_s[i], in_ready_s[i], busy_s[i], k == lat, k > lat, k <= lat);
          end
          if (k == lat) begin
            n_cmp++;
            if (data_out_s[i] !== e) begin
              n_bad++;
              $display("FAIL data blk%0d inst%0d: got %h, required %h", v, i, data_out_s[i], e);
            end
          end
        end
      end
    end
  endtask

  task automatic test_backpressure();
    logic [127:0] a, bb;
    a  = rand128();
    bb = rand128();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; data_in = a; bypass = 1'b0; inverse_s = 1'b0;
    @(posedge clk);
    #1;
    data_in = bb;
    repeat (4) @(posedge clk);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (out_valid_s[i] !== 1'b1 || in_ready_s[i] !== 1'b0 || data_out_s[i] !== ref_state(a, 1'b0, 1'b0)) begin
          n_bad++;
          $display("FAIL hold inst%0d k=%0d: vld=%b rdy=%b dout=%h, required 1 0 %h",
                   i, k, out_valid_s[i], in_ready_s[i], data_out_s[i], ref_state(a, 1'b0, 1'b0));
        end
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid_s[i] !== 1'b0 || in_ready_s[i] !== 1'b1) begin
        n_bad++;
        $display("FAIL xfer inst%0d: vld=%b rdy=%b, required 0 1", i, out_valid_s[i], in_ready_s[i]);
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; data_in = rand128();
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid_s[i] !== 1'b1 || data_out_s[i] !== ref_state(bb, 1'b0, 1'b0)) begin
        n_bad++;
        $display("FAIL second inst%0d: vld=%b dout=%h, required 1 %h",
                 i, out_valid_s[i], data_out_s[i], ref_state(bb, 1'b0, 1'b0));
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset_mid_proc();
    logic [127:0] d;
    @(negedge clk);
    out_ready = 1'b1; in_valid = 1'b1; data_in = rand128(); bypass = 1'b0; inverse_s = 1'b0;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_rst = 1'b0;
    #1;
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid_s[i] !== 1'b0 || in_ready_s[i] !== 1'b1 || busy_s[i] !== 1'b0 || data_out_s[i] !== 128'h0) begin
        n_bad++;
        $display("FAIL midrst inst%0d: vld=%b rdy=%b busy=%b dout=%h, required 0 1 0 0",
                 i, out_valid_s[i], in_ready_s[i], busy_s[i], data_out_s[i]);
      end
    end
    @(negedge clk);
    n_rst = 1'b1;
    d = rand128();
    @(negedge clk);
    out_ready = 1'b0; in_valid = 1'b1; data_in = d;
    @(posedge clk);
    #1;
    in_valid = 1'b0; data_in = rand128();
    repeat (4) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      n_cmp++;
      if (out_valid_s[i] !== 1'b1 || data_out_s[i] !== ref_state(d, 1'b0, 1'b0)) begin
        n_bad++;
        $display("FAIL afterrst inst%0d: vld=%b dout=%h, required 1 %h",
                 i, out_valid_s[i], data_out_s[i], ref_state(d, 1'b0, 1'b0));
      end
    end
    out_ready = 1'b1;
    @(posedge clk);
    #1;
  endtask

  initial begin
    n_cmp = 0;
    n_bad = 0;
    test_reset();
    test_blocks();
    test_backpressure();
    test_reset_mid_proc();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
